sd_spi_arbiter: RTL and testbench

Shares the single SD-card SPI engine (SCLK/MOSI/MISO plus the two card selects) between two byte-level requesters: requester 0 is the CPU port path (the 0xE7/0xEB decode), requester 1 is an autonomous agent such as a boot/config loader. The block owns the shift register and chip-select pins. It arbitrates round-robin per transaction and lets the owner lock the bus across multi-byte transactions so card selects stay asserted.

---
 rtl/sd_spi_arbiter.sv | 147 ++++++++++++++
 tb/tb_sd_spi_arbiter.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_spi_arbiter.sv
// Two-requester arbiter around a single mode-0 SPI byte engine for the SD card.
// Round-robin per transaction, with an owner lock that keeps card select asserted.
module sd_spi_arbiter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0,
    input  logic       req1,
    input  logic       lock0,
    input  logic       lock1,
    input  logic [7:0] wdata0,
    input  logic [7:0] wdata1,
    input  logic [1:0] csel0,
    input  logic [1:0] csel1,
    output logic       ack0,
    output logic       ack1,
    output logic [7:0] rdata,
    output logic       owner,
    output logic       busy,
    output logic       sd_cs0_n,
    output logic       sd_cs1_n,
    output logic       sd_sclk,
    output logic       sd_mosi,
    input  logic       sd_miso
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_DONE,
        ST_HOLD
    } state_t;

    state_t     state_q, state_d;
    logic       owner_q, owner_d;
    logic       last_owner_q, last_owner_d;
    logic [7:0] shreg_q, shreg_d;
    logic [7:0] rdata_q, rdata_d;
    logic [3:0] cnt_q, cnt_d;
    logic [1:0] cs_q, cs_d;
    logic       grant;

    logic       req_own;
    logic       lock_own;
    logic [7:0] wdata_own;
    logic [1:0] csel_own;

    assign req_own   = owner_q ? req1   : req0;
    assign lock_own  = owner_q ? lock1  : lock0;
    assign wdata_own = owner_q ? wdata1 : wdata0;
    assign csel_own  = owner_q ? csel1  : csel0;

    // NOTE: every next-state variable gets a default first so no path leaves one unassigned (no latches).
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        shreg_d      = shreg_q;
        rdata_d      = rdata_q;
        cnt_d        = cnt_q;
        cs_d         = cs_q;
        grant        = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (req0 || req1) begin
                    grant        = (req0 && req1) ? ~last_owner_q : req1;
                    owner_d      = grant;
                    last_owner_d = grant;
                    state_d      = ST_LOAD;
                end
            end
            ST_LOAD: begin
                shreg_d = wdata_own;
                cnt_d   = 4'd0;
                // Selecting both cards at once is illegal; deselect both and still clock the byte.
                cs_d    = (csel_own == 2'b00) ? 2'b11 : csel_own;
                state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (cnt_q[0]) begin
                    shreg_d = {shreg_q[6:0], sd_miso};
                end
                if (cnt_q == 4'd15) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ST_DONE: begin
                rdata_d = shreg_q;
                shreg_d = 8'hFF;
                if (lock_own) begin
                    state_d = ST_HOLD;
                end else begin
                    state_d = ST_IDLE;
                    cs_d    = 2'b11;
                end
            end
            ST_HOLD: begin
                if (req_own) begin
                    state_d = ST_LOAD;
                end else if (!lock_own) begin
                    state_d = ST_IDLE;
                    cs_d    = 2'b11;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cs_d    = 2'b11;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            owner_q      <= 1'b0;
            last_owner_q <= 1'b1;
            shreg_q      <= 8'hFF;
            rdata_q      <= 8'hFF;
            cnt_q        <= 4'd0;
            cs_q         <= 2'b11;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            shreg_q      <= shreg_d;
            rdata_q      <= rdata_d;
            cnt_q        <= cnt_d;
            cs_q         <= cs_d;
        end
    end

    // Outputs decode registered state only; nothing combinational from the request inputs.
    assign ack0     = (state_q == ST_DONE) && !owner_q;
    assign ack1     = (state_q == ST_DONE) &&  owner_q;
    assign rdata    = rdata_q;
    assign owner    = owner_q;
    assign busy     = (state_q != ST_IDLE);
    assign sd_cs1_n = cs_q[1];
    assign sd_cs0_n = cs_q[0];
    assign sd_sclk  = (state_q == ST_SHIFT) && cnt_q[0];
    assign sd_mosi  = (state_q == ST_SHIFT) ? shreg_q[7] : 1'b1;

endmodule

// File: tb/tb_sd_spi_arbiter.sv
// Scoreboard bench for sd_spi_arbiter: drivers push expected bytes per requester,
// a bus monitor reconstructs each SPI byte and compares at every ack.
module tb_sd_spi_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req0, req1, lock0, lock1;
    logic [7:0] wdata0, wdata1;
    logic [1:0] csel0, csel1;
    logic       ack0, ack1;
    logic [7:0] rdata;
    logic       owner, busy;
    logic       sd_cs0_n, sd_cs1_n, sd_sclk, sd_mosi, sd_miso;

    typedef struct packed {
        logic [7:0] wd;
        logic [7:0] rd;
        logic [1:0] cs;
        logic       lk;
    } exp_t;

    exp_t       sb_q [2][$];
    int         n_vec = 0;
    int         n_bad = 0;
    int         ack0_cnt = 0;

    logic [7:0] miso_pat [2];
    logic [2:0] falls = 3'd0;

    sd_spi_arbiter dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req0     (req0),
        .req1     (req1),
        .lock0    (lock0),
        .lock1    (lock1),
        .wdata0   (wdata0),
        .wdata1   (wdata1),
        .csel0    (csel0),
        .csel1    (csel1),
        .ack0     (ack0),
        .ack1     (ack1),
        .rdata    (rdata),
        .owner    (owner),
        .busy     (busy),
        .sd_cs0_n (sd_cs0_n),
        .sd_cs1_n (sd_cs1_n),
        .sd_sclk  (sd_sclk),
        .sd_mosi  (sd_mosi),
        .sd_miso  (sd_miso)
    );

    always #5 clk = ~clk;

    // Card model: presents the owner's MISO pattern MSB first, advancing on each SCLK fall.
    always @(negedge sd_sclk) falls <= falls + 3'd1;
    always @(posedge rst_n) falls <= 3'd0;
    assign sd_miso = miso_pat[owner][3'd7 - falls];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_ack0"},  ack0, 0);
        check({tag, "_ack1"},  ack1, 0);
        check({tag, "_rdata"}, rdata, 8'hFF);
        check({tag, "_owner"}, owner, 0);
        check({tag, "_busy"},  busy, 0);
        check({tag, "_cs"},    {sd_cs1_n, sd_cs0_n}, 2'b11);
        check({tag, "_sclk"},  sd_sclk, 0);
        check({tag, "_mosi"},  sd_mosi, 1);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        req0 = 0; req1 = 0; lock0 = 0; lock1 = 0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // One byte for requester `who`; called just after a clock edge.
    task automatic xfer(input bit who, input logic [7:0] wd, input logic [1:0] cs,
                        input logic [7:0] mi, input bit lk, input bit keep_req,
                        input logic [1:0] exp_cs, input int exp_lat);
        int cycles;
        exp_t e;
        e.wd = wd; e.rd = mi; e.cs = exp_cs; e.lk = lk;
        sb_q[who].push_back(e);
        miso_pat[who] = mi;
        if (who) begin
            wdata1 = wd; csel1 = cs; lock1 = lk; req1 = 1'b1;
        end else begin
            wdata0 = wd; csel0 = cs; lock0 = lk; req0 = 1'b1;
        end
        cycles = 0;
        forever begin
            @(negedge clk);
            if (who ? ack1 : ack0) break;
            if (cycles > 200) begin
                check("ack_timeout", 1, 0);
                break;
            end
            @(posedge clk);
            cycles++;
        end
        if (exp_lat >= 0) check("ack_latency", cycles, exp_lat);
        @(posedge clk);
        #1;
        if (!keep_req) begin
            if (who) begin req1 = 1'b0; lock1 = 1'b0; end
            else     begin req0 = 1'b0; lock0 = 1'b0; end
        end
    endtask

    // Bus monitor: rebuilds each byte from SCLK rising edges and scores it at ack.
    int         edges;
    logic [7:0] mosi_cap;
    logic [1:0] cs_cap;
    bit         cs_varied, mosi_moved, sclk_prev, mosi_prev, rd_pend;
    exp_t       rd_item;

    always @(negedge clk) begin
        if (!rst_n) begin
            edges = 0; cs_varied = 0; mosi_moved = 0;
            sclk_prev = 0; mosi_prev = 1; rd_pend = 0;
        end else begin
            if (rd_pend) begin
                rd_pend = 0;
                check("rdata", rdata, rd_item.rd);
                if (rd_item.lk) begin
                    check("hold_busy", busy, 1);
                    check("hold_cs", {sd_cs1_n, sd_cs0_n}, rd_item.cs);
                end else begin
                    check("idle_busy", busy, 0);
                    check("idle_cs", {sd_cs1_n, sd_cs0_n}, 2'b11);
                    check("idle_mosi", sd_mosi, 1);
                end
            end
            if (sd_sclk && !sclk_prev) begin
                if (sd_mosi !== mosi_prev) mosi_moved = 1;
                if (edges > 0 && {sd_cs1_n, sd_cs0_n} !== cs_cap) cs_varied = 1;
                cs_cap   = {sd_cs1_n, sd_cs0_n};
                mosi_cap = {mosi_cap[6:0], sd_mosi};
                edges++;
            end
            if (ack0 || ack1) begin
                automatic bit who = ack1;
                if (ack0) ack0_cnt++;
                if (ack0 && ack1) check("ack_both", 1, 0);
                if (sb_q[who].size() == 0) begin
                    check(who ? "unexpected_ack1" : "unexpected_ack0", 1, 0);
                end else begin
                    automatic exp_t e = sb_q[who].pop_front();
                    check("owner", owner, who);
                    check("mosi_byte", mosi_cap, e.wd);
                    check("sclk_edges", edges, 8);
                    check("cs_during_byte", cs_cap, e.cs);
                    check("cs_stable", cs_varied, 0);
                    check("mosi_setup", mosi_moved, 0);
                    rd_pend = 1;
                    rd_item = e;
                end
                edges = 0; cs_varied = 0; mosi_moved = 0;
            end
            sclk_prev = sd_sclk;
            mosi_prev = sd_mosi;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion, expected $finish before %0t", $time);
        n_bad++;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        wdata0 = 8'h00; wdata1 = 8'h00; csel0 = 2'b11; csel1 = 2'b11;
        miso_pat[0] = 8'hFF; miso_pat[1] = 8'hFF;
        apply_reset();
        check_reset_values("reset");

        // Single byte: A5 out, 3C in, card 0 selected.
        xfer(0, 8'hA5, 2'b10, 8'h3C, 0, 0, 2'b10, 18);
        // Illegal csel 00: byte still clocked, both selects stay high.
        xfer(0, 8'h55, 2'b00, 8'h0F, 0, 0, 2'b11, 18);

        // Requester 1 locks three bytes while requester 0 waits.
        fork
            begin
                automatic int a0 = ack0_cnt;
                xfer(1, 8'h81, 2'b01, 8'h12, 1, 1, 2'b01, 18);
                xfer(1, 8'h7E, 2'b01, 8'h34, 1, 1, 2'b01, 18);
                xfer(1, 8'hC3, 2'b01, 8'h56, 1, 0, 2'b01, 18);
                check("no_ack0_during_lock", ack0_cnt, a0);
            end
            begin
                repeat (5) @(posedge clk);
                #1;
                xfer(0, 8'h99, 2'b10, 8'hAA, 0, 0, 2'b10, -1);
            end
        join

        // Tie from reset: requester 0 first, then 1; repeated tie does the same.
        @(posedge clk);
        apply_reset();
        fork
            xfer(0, 8'h5A, 2'b10, 8'h66, 0, 0, 2'b10, 18);
            xfer(1, 8'h3C, 2'b01, 8'h99, 0, 0, 2'b01, 37);
        join
        fork
            xfer(0, 8'h0F, 2'b10, 8'hF0, 0, 0, 2'b10, 18);
            xfer(1, 8'hE7, 2'b01, 8'h18, 0, 0, 2'b01, 37);
        join

        // Reset in the middle of a byte (cnt = 7): nothing acked, rdata stays FF.
        @(posedge clk);
        #1;
        wdata0 = 8'hE1; csel0 = 2'b10; miso_pat[0] = 8'h00; req0 = 1'b1;
        repeat (9) @(posedge clk);
        #2;
        check("pre_abort_sclk_high", sd_sclk, 1);
        rst_n = 1'b0;
        req0  = 1'b0;
        #1;
        check_reset_values("abort");
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (25) @(posedge clk);
        #1;
        check("abort_rdata_held", rdata, 8'hFF);
        check("abort_no_busy", busy, 0);
        xfer(0, 8'h3C, 2'b10, 8'hC5, 0, 0, 2'b10, 18);

        repeat (5) @(posedge clk);
        check("sb0_drained", sb_q[0].size(), 0);
        check("sb1_drained", sb_q[1].size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
